// File: rtl/shift_add_mult_4bit.sv
// shift_add_mult_4bit: sequential unsigned shift-and-add multiplier with start/busy/done handshake
module shift_add_mult_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] m, acc, q;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] sum, acc_nxt;
    assign sum = {1'b0, acc} + {1'b0, m};
    // {C,ACC}: carry lives in the top bit and is shifted straight into ACC
    assign acc_nxt = q[0] ? sum : {1'b0, acc};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    m     <= a_in;
                    q     <= b_in;
                    acc   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= CALC;
                end
                CALC: begin
                    acc <= acc_nxt[WIDTH:1];
                    q   <= {acc_nxt[0], q[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    product <= {acc, q};
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mult_4bit.sv
// tb_shift_add_mult_4bit: randomized scenario bench for the shift-and-add multiplier
module tb_shift_add_mult_4bit;
    logic clk = 0, rst_n = 0, start = 0;
    logic [3:0] a_in = 0, b_in = 0;
    logic busy, done;
    logic [7:0] product;
    int total = 0, bad = 0;

    shift_add_mult_4bit #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    // Issue one operation and observe 8 cycles; a stray start is pulsed at cycle ign (0 = none)
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int ign,
                          output int busy_n, output int done_n, output int done_at,
                          output logic [7:0] prod, output logic [7:0] prod_end, output logic both);
        busy_n = 0; done_n = 0; done_at = -1; prod = 'x; both = 0;
        @(negedge clk);
        a_in = a; b_in = b; start = 1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin done_n++; done_at = j; prod = product; end
            if (busy && done) both = 1;
            start = (j == ign);
            a_in = (j == ign) ? 4'hF : 4'($urandom);
            b_in = (j == ign) ? 4'hF : 4'($urandom);
        end
        start = 0;
        prod_end = product;
    endtask

    task automatic test_reset;
        rst_n = 0; start = 0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (product !== 8'h00) begin bad++; $display("FAIL reset_product got=%h want=00", product); end
        rst_n = 1;
    endtask

    task automatic test_directed;
        logic [3:0] ta [5] = '{4'd15, 4'd0, 4'd9, 4'd7, 4'd1};
        logic [3:0] tb [5] = '{4'd15, 4'd9, 4'd0, 4'd1, 4'd11};
        int bn, dn, da; logic [7:0] p, pe; logic bo;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], 0, bn, dn, da, p, pe, bo);
            total++; if (p !== 8'(ta[i] * tb[i])) begin bad++; $display("FAIL dir_product a=%0d b=%0d got=%0d want=%0d", ta[i], tb[i], p, ta[i] * tb[i]); end
            total++; if (bn != 4) begin bad++; $display("FAIL dir_busy_cycles got=%0d want=4", bn); end
            total++; if (dn != 1 || da != 6) begin bad++; $display("FAIL dir_done count=%0d at=%0d want count=1 at=6", dn, da); end
            total++; if (bo) begin bad++; $display("FAIL dir_busy_done_overlap got=1 want=0"); end
            total++; if (pe !== p) begin bad++; $display("FAIL dir_product_hold got=%0d want=%0d", pe, p); end
        end
    endtask

    task automatic test_ignore_start;
        int bn, dn, da; logic [7:0] p, pe; logic bo;
        run_op(4'd3, 4'd5, 2, bn, dn, da, p, pe, bo);
        total++; if (p !== 8'd15) begin bad++; $display("FAIL ignore_product got=%0d want=15", p); end
        total++; if (dn != 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", dn); end
        total++; if (pe !== 8'd15 || busy !== 1'b0) begin bad++; $display("FAIL ignore_no_reload product=%0d busy=%b want 15/0", pe, busy); end
    endtask

    task automatic test_abort;
        int bn, dn, da, spur; logic [7:0] p, pe; logic bo;
        @(negedge clk);
        a_in = 4'd12; b_in = 4'd10; start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b want=1", busy); end
        rst_n = 0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_async busy=%b done=%b want 0/0", busy, done); end
        total++; if (product !== 8'h00) begin bad++; $display("FAIL abort_product got=%0d want=0", product); end
        @(negedge clk);
        rst_n = 1;
        spur = 0;
        repeat (8) begin @(negedge clk); if (done || busy) spur++; end
        total++; if (spur != 0) begin bad++; $display("FAIL abort_spurious got=%0d want=0", spur); end
        run_op(4'd12, 4'd10, 0, bn, dn, da, p, pe, bo);
        total++; if (p !== 8'd120 || dn != 1) begin bad++; $display("FAIL abort_restart got=%0d dones=%0d want=120/1", p, dn); end
    endtask

    task automatic test_hold_start;
        int dn = 0, last = -1, gap_bad = 0, prod_bad = 0;
        @(negedge clk);
        a_in = 4'd6; b_in = 4'd13; start = 1;
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                if (product !== 8'd78) prod_bad++;
                if (last >= 0 && j - last != 6) gap_bad++;
                last = j;
            end
        end
        start = 0;
        repeat (8) @(negedge clk);
        total++; if (dn != 4) begin bad++; $display("FAIL hold_done_count got=%0d want=4", dn); end
        total++; if (gap_bad != 0) begin bad++; $display("FAIL hold_spacing bad_gaps=%0d want=0", gap_bad); end
        total++; if (prod_bad != 0) begin bad++; $display("FAIL hold_product bad=%0d want=0", prod_bad); end
    endtask

    task automatic test_sweep;
        int bn, dn, da; logic [7:0] p, pe; logic bo;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), int'($urandom_range(0, 5)), bn, dn, da, p, pe, bo);
                total++; if (p !== 8'(a * b) || pe !== 8'(a * b)) begin bad++; $display("FAIL sweep a=%0d b=%0d got=%0d held=%0d want=%0d", a, b, p, pe, a * b); end
                total++; if (dn != 1 || da != 6 || bn != 4 || bo) begin bad++; $display("FAIL sweep_timing a=%0d b=%0d dones=%0d at=%0d busy=%0d overlap=%b want 1/6/4/0", a, b, dn, da, bn, bo); end
            end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignore_start;
        test_abort;
        test_hold_start;
        test_sweep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
